// File: rtl/mac_arb_pkg.sv
// rtl/mac_arb_pkg.sv - shared state encoding and default parameters for mac_arbiter
package mac_arb_pkg;

  localparam int NUM_REQ_DEF        = 4;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int ADDR_LINES_DEF     = 5;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t GRANT = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection starting at ptr
module rr_picker
  import mac_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index
);

  // Scan offsets from farthest to nearest so the requester closest to ptr overwrites the rest.
  always_comb begin
    winner = '0;
    index  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req[k] && (k == (int'(ptr) + i) % NUM_REQ)) begin
          winner    = '0;
          winner[k] = 1'b1;
          index     = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// rtl/mac_arbiter.sv - round-robin arbiter sharing one mac between requesters, with watchdog abort
module mac_arbiter
  import mac_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_LINES     = ADDR_LINES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_LINES-1:0] req_terms_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          mac_start_o,
  output logic [ADDR_LINES-1:0]         mac_terms_o,
  output logic                          mac_flush_o,
  input  logic                          mac_done_i,
  input  logic [DATA_WIDTH-1:0]         mac_result_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [WD_W-1:0]    watchdog;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (req_i),
    .ptr   (rr_ptr),
    .winner(pick_oh),
    .index (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      watchdog    <= '0;
      gnt_o       <= '0;
      mac_start_o <= 1'b0;
      mac_terms_o <= '0;
      mac_flush_o <= 1'b0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      mac_start_o <= 1'b0;
      mac_flush_o <= 1'b0;
      rsp_valid_o <= '0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner       <= pick_idx;
            gnt_o       <= pick_oh;
            mac_terms_o <= req_terms_i[int'(pick_idx)*ADDR_LINES +: ADDR_LINES];
            busy_o      <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          mac_start_o <= 1'b1;
          watchdog    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          watchdog <= watchdog + 1'b1;
          // A completion on the final watchdog cycle still counts as a good result.
          if (mac_done_i) begin
            rsp_data_o <= mac_result_i;
            rsp_err_o  <= 1'b0;
            state      <= RESP;
          end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            mac_flush_o <= 1'b1;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          rsp_valid_o <= gnt_o;
          rr_ptr      <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          gnt_o       <= '0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          gnt_o  <= '0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// tb/tb_mac_arbiter.sv - scoreboard bench for mac_arbiter with directed operations
module tb_mac_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  req_i;
  logic [19:0] req_terms_i;
  logic [3:0]  gnt_o;
  logic        mac_start_o;
  logic [4:0]  mac_terms_o;
  logic        mac_flush_o;
  logic        mac_done_i;
  logic [31:0] mac_result_i;
  logic [3:0]  rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int flush_cnt = 0;
  logic [36:0] exp_q[$];

  mac_arbiter #(
    .NUM_REQ       (4),
    .DATA_WIDTH    (32),
    .ADDR_LINES    (5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (req_i),
    .req_terms_i (req_terms_i),
    .gnt_o       (gnt_o),
    .mac_start_o (mac_start_o),
    .mac_terms_o (mac_terms_o),
    .mac_flush_o (mac_flush_o),
    .mac_done_i  (mac_done_i),
    .mac_result_i(mac_result_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every response strobe must match the oldest expectation.
  always @(negedge clk_i) begin
    logic [36:0] e;
    if (rstn_i && mac_flush_o) flush_cnt++;
    if (rsp_valid_o != 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected act valid=%b data=%h err=%b req none", rsp_valid_o, rsp_data_o, rsp_err_o);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_valid_o, rsp_data_o, rsp_err_o} !== e) begin
          errors++;
          $display("FAIL rsp act valid=%b data=%h err=%b req valid=%b data=%h err=%b",
                   rsp_valid_o, rsp_data_o, rsp_err_o, e[36:33], e[32:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {15'b0, gnt_o, mac_start_o, mac_terms_o, mac_flush_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o};
  endfunction

  task automatic op(input logic [3:0] req, input logic [19:0] terms, input logic [3:0] exp_gnt,
                    input logic [4:0] exp_terms, input int delay, input logic [31:0] result,
                    input bit timeout, input bit drop);
    int n;
    int fl0;
    req_i       = req;
    req_terms_i = terms;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt_o == 4'b0 && n < 8);
    chk("grant_latency", n, 1);
    chk("gnt", gnt_o, exp_gnt);
    chk("terms_at_grant", mac_terms_o, exp_terms);
    req_terms_i = ~terms;
    tick();
    chk("start_pulse", {mac_start_o, busy_o}, 2'b11);
    chk("terms_held", mac_terms_o, exp_terms);
    if (drop) req_i = 4'b0;
    fl0 = flush_cnt;
    tick();
    chk("start_single", mac_start_o, 0);
    if (!timeout) begin
      repeat (delay - 1) tick();
      mac_done_i   = 1'b1;
      mac_result_i = result;
      exp_q.push_back({exp_gnt, result, 1'b0});
      tick();
      mac_done_i   = 1'b0;
      mac_result_i = 32'hDEAD_BEEF;
    end else begin
      exp_q.push_back({exp_gnt, 32'h0, 1'b1});
      n = 1;
      while (!mac_flush_o && n < 40) begin
        tick();
        n++;
      end
      chk("flush_delay", n, 16);
    end
    n = 0;
    while (busy_o && n < 40) begin
      tick();
      n++;
    end
    chk("busy_release", busy_o, 0);
    chk("flush_count", flush_cnt - fl0, timeout ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1);
  end

  initial begin
    rstn_i       = 1'b0;
    req_i        = 4'b0;
    req_terms_i  = 20'b0;
    mac_done_i   = 1'b0;
    mac_result_i = 32'b0;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 0);
    rstn_i = 1'b1;
    tick();

    // Fairness: all requesters held, grant order 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      op(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 4'(1 << (k % 4)), 5'((k % 4) + 1),
         1 + (k % 3), 32'h1000 + k, 1'b0, k == 7);
    end

    // Single request, done 10 cycles after start.
    op(4'b0100, {5'd0, 5'd7, 5'd0, 5'd3}, 4'b0100, 5'd7, 10, 32'hA5A5_1234, 1'b0, 1'b1);

    // Timeout with no completion.
    op(4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 4'b0010, 5'd9, 0, 32'h0, 1'b1, 1'b1);

    // Done on the last watchdog cycle, terms value zero.
    op(4'b0001, 20'b0, 4'b0001, 5'd0, 15, 32'hC011_1DE5, 1'b0, 1'b1);

    // Stray done while idle.
    mac_done_i   = 1'b1;
    mac_result_i = 32'h5757_5757;
    repeat (3) tick();
    chk("stray_done_outs", {gnt_o, busy_o, mac_start_o, rsp_data_o}, {4'b0, 1'b0, 1'b0, 32'hC011_1DE5});
    mac_done_i = 1'b0;

    // Reset in the middle of WAIT drops the operation.
    req_i       = 4'b1000;
    req_terms_i = {5'd11, 15'b0};
    tick();
    chk("rst_case_gnt", gnt_o, 4'b1000);
    tick();
    req_i = 4'b0;
    repeat (3) tick();
    chk("rst_case_busy", busy_o, 1);
    rstn_i = 1'b0;
    tick();
    chk("mid_reset_outputs", all_outs(), 0);
    rstn_i = 1'b1;
    repeat (5) tick();
    chk("post_reset_idle", {gnt_o, busy_o, mac_flush_o}, 0);

    // Pointer back at zero: full request picks requester 0.
    op(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0001, 5'd1, 2, 32'h0000_600D, 1'b0, 1'b1);

    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one mac instance.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the result path.
REQ-003 SHALL have parameter ADDR_LINES, default 5, width of the terms field.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum WAIT duration before abort.
REQ-005 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-006 SHALL have port rstn_i, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port req_i, input, NUM_REQ, per-requester level request.
REQ-008 SHALL have port req_terms_i, input, NUM_REQ x ADDR_LINES, per-requester term count.
REQ-009 SHALL have port gnt_o, output, NUM_REQ, one-hot grant, held for the whole operation.
REQ-010 SHALL have port mac_start_o, output, 1, single-cycle start pulse to mac.
REQ-011 SHALL have port mac_terms_o, output, ADDR_LINES, terms latched at grant.
REQ-012 SHALL have port mac_flush_o, output, 1, single-cycle datapath flush on abort.
REQ-013 SHALL have port mac_done_i, input, 1, mac completion flag.
REQ-014 SHALL have port mac_result_i, input, DATA_WIDTH, mac result, valid with mac_done_i.
REQ-015 SHALL have port rsp_valid_o, output, NUM_REQ, one-hot single-cycle response strobe.
REQ-016 SHALL have port rsp_data_o, output, DATA_WIDTH, response data, shared by all requesters.
REQ-017 SHALL have port rsp_err_o, output, 1, high with rsp_valid_o when the operation timed out.
REQ-018 SHALL have port busy_o, output, 1, high in every state except IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> GRANT -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-020 IDLE: if any req_i bit is set, SHALL select one winner round-robin, starting at pointer rr_ptr; register owner, gnt_o = one-hot(owner), and mac_terms_o = req_terms_i[owner]; go to GRANT.
REQ-021 GRANT: SHALL assert mac_start_o for exactly one cycle, clear the watchdog, and go to WAIT.
REQ-022 WAIT: SHALL increment the watchdog each cycle; on mac_done_i, SHALL latch mac_result_i into rsp_data_o, set rsp_err_o = 0, and go to RESP.
REQ-023 WAIT: if the watchdog reaches TIMEOUT_CYCLES-1 with no mac_done_i, SHALL pulse mac_flush_o, set rsp_data_o = 0 and rsp_err_o = 1, and go to RESP; if mac_done_i arrives on that same cycle, done wins.
REQ-024 RESP: SHALL assert rsp_valid_o[owner] for one cycle, set rr_ptr = (owner+1) mod NUM_REQ, clear gnt_o, and go to IDLE.
REQ-025 Latency: req_i sampled in IDLE at cycle 0 -> gnt_o at cycle 1 -> mac_start_o at cycle 2; rsp_valid_o comes 2 cycles after mac_done_i.
REQ-026 Minimum spacing between consecutive grants SHALL be 1 IDLE cycle, so back-to-back operations restart every 4+N cycles.
REQ-027 Deasserting req_i[owner] after grant SHALL NOT abort the operation; the response is still issued.
REQ-028 mac_done_i outside WAIT SHALL be ignored.
REQ-029 req_terms_i changes after grant SHALL NOT affect mac_terms_o.
REQ-030 Terms value 0 SHALL be passed through unmodified; the mac adds its own offset.
REQ-031 Non-owner req_i SHALL be ignored until the arbiter returns to IDLE.

Reset
REQ-032 While rstn_i = 0 at a clock edge: state = IDLE, rr_ptr = 0, owner = 0, watchdog = 0; gnt_o, rsp_valid_o, mac_start_o, mac_flush_o, rsp_err_o, and busy_o = 0; mac_terms_o = 0; rsp_data_o = 0.
REQ-033 Reset during GRANT, WAIT, or RESP SHALL drop the operation with no response and no flush pulse.

Structure
REQ-034 Package mac_arb_pkg SHALL hold the state enum (IDLE, GRANT, WAIT, RESP) and the default parameter constants.
REQ-035 Winner selection SHALL be a combinational sub-module rr_picker(req, ptr -> one-hot winner, index).
REQ-036 Watchdog width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits.

Verification
REQ-037 Single request: req_i = 4'b0100, terms = 7, mac_done_i 10 cycles after start -> gnt_o = 0100 at cycle 1, mac_start_o at cycle 2, mac_terms_o = 7, rsp_valid_o = 0100 with mac_result_i value and rsp_err_o = 0.
REQ-038 Fairness: req_i = 4'b1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3.
REQ-039 Timeout: TIMEOUT_CYCLES = 16, mac_done_i never asserted -> mac_flush_o pulse 16 cycles after start; rsp_err_o = 1 and rsp_data_o = 0 on the owner strobe.
REQ-040 Done collides with timeout: done on the last watchdog cycle -> rsp_err_o = 0, result delivered, no flush.
REQ-041 Reset mid-WAIT: rstn_i low for 1 cycle -> all outputs 0 next cycle and no rsp_valid_o; then req_i = 0001 is granted normally with rr_ptr = 0.
REQ-042 Request drop and stray done: owner deasserts req_i in WAIT -> response still issued; mac_done_i in IDLE -> no output change.
